// File: rtl/ifm_window_reader.sv
// IFM window reader: walks every KxK window of one IFM bank and
// issues the elements two at a time on the A/B read ports.
module ifm_window_reader #(
  parameter int DATA_WIDTH       = 32,
  parameter int IFM_SIZE         = 14,
  parameter int KERNEL_SIZE      = 5,
  parameter int ADDRESS_SIZE_IFM = $clog2(IFM_SIZE*IFM_SIZE)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        hold,
  output logic                        ifm_sel,
  output logic                        ifm_enable_read_A_next,
  output logic                        ifm_enable_read_B_next,
  output logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_A_next,
  output logic [ADDRESS_SIZE_IFM-1:0] ifm_address_read_B_next,
  input  logic [DATA_WIDTH-1:0]       data_in_A,
  input  logic [DATA_WIDTH-1:0]       data_in_B,
  output logic [DATA_WIDTH-1:0]       data_A,
  output logic [DATA_WIDTH-1:0]       data_B,
  output logic                        valid_A,
  output logic                        valid_B,
  output logic                        window_last,
  output logic                        busy,
  output logic                        done
);

  localparam int K   = KERNEL_SIZE;
  localparam int KK  = K * K;
  localparam int OUT = IFM_SIZE - K + 1;
  localparam int AW  = ADDRESS_SIZE_IFM;
  localparam int CW  = $clog2(IFM_SIZE + 2);
  localparam int EW  = $clog2(KK + 2);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [CW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic [CW-1:0] ec_q, ec_d;
  logic [EW-1:0] e_q, e_d;
  logic [AW-1:0] base_q, base_d;
  logic [AW-1:0] row_q, row_d;
  logic          sel_q, sel_d;
  logic          va_q, va_d;
  logic          vb_q, vb_d;
  logic          wl_q, wl_d;

  logic          issue;
  logic          b_on;
  logic          b_wrap;
  logic          win_end;
  logic          last_win;
  logic [AW-1:0] elem_a;
  logic [AW-1:0] elem_b;

  // base_q = r*IFM+c, row_q = (e/K)*IFM: sums only, no multiplier
  assign elem_a   = base_q + row_q + AW'(ec_q);
  assign b_wrap   = (ec_q == CW'(K - 1));
  assign elem_b   = b_wrap ? (base_q + row_q + AW'(IFM_SIZE))
                           : (elem_a + AW'(1));
  assign issue    = (state_q == READ) && !hold;
  assign b_on     = (e_q != EW'(KK - 1));
  assign win_end  = (e_q >= EW'(KK - 2));
  assign last_win = (r_q == CW'(OUT - 1)) && (c_q == CW'(OUT - 1));

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    c_d     = c_q;
    ec_d    = ec_q;
    e_d     = e_q;
    base_d  = base_q;
    row_d   = row_q;
    sel_d   = sel_q;
    va_d    = issue;
    vb_d    = issue && b_on;
    wl_d    = issue && win_end;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = READ;
          sel_d   = ~sel_q;
          r_d     = '0;
          c_d     = '0;
          ec_d    = '0;
          e_d     = '0;
          base_d  = '0;
          row_d   = '0;
        end
      end
      READ: begin
        if (issue && win_end) begin
          e_d   = '0;
          ec_d  = '0;
          row_d = '0;
          if (last_win) begin
            state_d = DONE;
            r_d     = '0;
            c_d     = '0;
            base_d  = '0;
          end else if (c_q == CW'(OUT - 1)) begin
            c_d    = '0;
            r_d    = r_q + CW'(1);
            base_d = base_q + AW'(K);
          end else begin
            c_d    = c_q + CW'(1);
            base_d = base_q + AW'(1);
          end
        end else if (issue) begin
          e_d = e_q + EW'(2);
          if (ec_q == CW'(K - 2)) begin
            ec_d  = '0;
            row_d = row_q + AW'(IFM_SIZE);
          end else if (b_wrap) begin
            ec_d  = CW'(1);
            row_d = row_q + AW'(IFM_SIZE);
          end else begin
            ec_d = ec_q + CW'(2);
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      r_q     <= '0;
      c_q     <= '0;
      ec_q    <= '0;
      e_q     <= '0;
      base_q  <= '0;
      row_q   <= '0;
      sel_q   <= 1'b0;
      va_q    <= 1'b0;
      vb_q    <= 1'b0;
      wl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      c_q     <= c_d;
      ec_q    <= ec_d;
      e_q     <= e_d;
      base_q  <= base_d;
      row_q   <= row_d;
      sel_q   <= sel_d;
      va_q    <= va_d;
      vb_q    <= vb_d;
      wl_q    <= wl_d;
    end
  end

  assign ifm_sel                 = sel_q;
  assign ifm_enable_read_A_next  = issue;
  assign ifm_enable_read_B_next  = issue && b_on;
  assign ifm_address_read_A_next = issue ? elem_a : '0;
  assign ifm_address_read_B_next = (issue && b_on) ? elem_b : '0;
  assign valid_A                 = va_q;
  assign valid_B                 = vb_q;
  assign window_last             = wl_q;
  assign data_A                  = va_q ? data_in_A : '0;
  assign data_B                  = vb_q ? data_in_B : '0;
  assign busy                    = (state_q != IDLE);
  assign done                    = (state_q == DONE);

endmodule

// File: tb/tb_ifm_window_reader.sv
// Randomized bench for ifm_window_reader against a window-arithmetic
// reference model with a 1-cycle-latency memory behind it.
module tb_ifm_window_reader;

  localparam int DW  = 32;
  localparam int IFM = 14;
  localparam int K   = 5;
  localparam int KK  = K * K;
  localparam int OUT = IFM - K + 1;
  localparam int AW  = $clog2(IFM * IFM);

  logic          clk = 1'b0;
  logic          reset, start, hold;
  logic          ifm_sel;
  logic          en_a, en_b;
  logic [AW-1:0] addr_a, addr_b;
  logic [DW-1:0] data_in_A, data_in_B;
  logic [DW-1:0] data_A, data_B;
  logic          valid_A, valid_B, window_last, busy, done;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mem [IFM*IFM];

  bit pv_a, pv_b, pwl;
  int pad_a, pad_b;

  ifm_window_reader #(
    .DATA_WIDTH(DW),
    .IFM_SIZE(IFM),
    .KERNEL_SIZE(K)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .hold(hold),
    .ifm_sel(ifm_sel),
    .ifm_enable_read_A_next(en_a),
    .ifm_enable_read_B_next(en_b),
    .ifm_address_read_A_next(addr_a),
    .ifm_address_read_B_next(addr_b),
    .data_in_A(data_in_A),
    .data_in_B(data_in_B),
    .data_A(data_A),
    .data_B(data_B),
    .valid_A(valid_A),
    .valid_B(valid_B),
    .window_last(window_last),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    data_in_A <= en_a ? mem[addr_a] : '0;
    data_in_B <= en_b ? mem[addr_b] : '0;
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, obs, exp);
    end
  endtask

  function automatic int addr_of(int r, int c, int e);
    return (r + e / K) * IFM + c + e % K;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_sel"}, ifm_sel, 0);
    chk({tag, "_ena"}, en_a, 0);
    chk({tag, "_enb"}, en_b, 0);
    chk({tag, "_adra"}, addr_a, 0);
    chk({tag, "_adrb"}, addr_b, 0);
    chk({tag, "_va"}, valid_A, 0);
    chk({tag, "_vb"}, valid_B, 0);
    chk({tag, "_wl"}, window_last, 0);
    chk({tag, "_da"}, data_A, 0);
    chk({tag, "_db"}, data_B, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic chk_valid();
    chk("valid_a", valid_A, pv_a);
    chk("valid_b", valid_B, pv_b);
    chk("wlast", window_last, pwl);
    if (pv_a) chk("data_a", data_A, mem[pad_a]);
    if (pv_b) chk("data_b", data_B, mem[pad_b]);
  endtask

  task automatic run_bank(input bit exp_sel, input bit holds,
                          input bit poke, input int abort_at);
    int  r, c, e, n, left;
    bit  h, fin, did3;
    r = 0; c = 0; e = 0; n = 0; left = 0;
    fin = 0; did3 = 0;
    pv_a = 0; pv_b = 0; pwl = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("sel_toggle", ifm_sel, exp_sel);
    chk("busy_start", busy, 1);
    for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
      if (holds && n == 5 && !did3) begin
        did3 = 1;
        left = 3;
      end
      if (left > 0) begin
        h = 1;
        left--;
      end else begin
        h = holds && ($urandom_range(0, 9) == 0);
      end
      if (abort_at >= 0 && n == abort_at) begin
        hold = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_zero("abort");
        return;
      end
      hold = h;
      start = poke && (cyc == 300);
      @(negedge clk);
      chk_valid();
      chk("sel_keep", ifm_sel, exp_sel);
      chk("en_a", en_a, !h);
      chk("en_b", en_b, !h && (e + 1 < KK));
      chk("adr_a", addr_a, h ? 0 : addr_of(r, c, e));
      chk("adr_b", addr_b, (h || e + 1 >= KK) ? 0 : addr_of(r, c, e + 1));
      if (!h) begin
        if (n == 0) chk("first_b", addr_b, 1);
        if (n == 2) chk("third_b", addr_b, 14);
        if (n == 12) chk("pair13_a", addr_a, 60);
        if (n == 13) chk("win2_b", addr_b, 2);
        if (n == 1287) chk("win99_first", addr_a, 135);
        if (n == 1299) chk("win99_last", addr_a, 195);
      end
      pv_a = !h;
      pv_b = !h && (e + 1 < KK);
      pwl  = !h && (e + 2 >= KK);
      pad_a = addr_of(r, c, e);
      pad_b = addr_of(r, c, e + 1);
      if (!h) begin
        n++;
        e += 2;
        if (e >= KK) begin
          e = 0;
          if (r == OUT - 1 && c == OUT - 1) fin = 1;
          else if (c == OUT - 1) begin
            c = 0;
            r++;
          end else c++;
        end
      end
      @(posedge clk); #1;
    end
    hold = 1'b0;
    start = 1'b0;
    if (!fin) begin
      chk("timeout", 0, 1);
      return;
    end
    chk("issue_count", n, 1300);
    @(negedge clk);
    chk_valid();
    chk("done_pulse", done, 1);
    chk("busy_done", busy, 1);
    chk("en_done", en_a, 0);
    @(posedge clk); #1;
    chk("done_clear", done, 0);
    chk("busy_clear", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < IFM * IFM; i++) mem[i] = $urandom;
    reset = 1'b1;
    start = 1'b0;
    hold  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 1'b0;
    @(posedge clk); #1;
    chk_zero("post_reset");
    run_bank(1'b1, 1'b0, 1'b0, -1);
    run_bank(1'b0, 1'b1, 1'b1, -1);
    run_bank(1'b1, 1'b0, 1'b0, 500);
    @(posedge clk); #1;
    chk("idle_after_abort", en_a, 0);
    run_bank(1'b1, 1'b0, 1'b0, -1);
    run_bank(1'b0, 1'b0, 1'b0, -1);
    chk("final_sel", ifm_sel, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
